// File: rtl/qpsk_tx_interp.sv
// QPSK transmit front end: symbol-rate I/Q in, L-times interpolated pulse-shaped I/Q out.
// Polyphase FIR with runtime-programmable taps, sticky underrun/saturation status.
module qpsk_tx_interp #(
    parameter int DW        = 16,
    parameter int CW        = 16,
    parameter int L         = 6,
    parameter int K         = 4,
    parameter int OUT_SHIFT = 15,
    localparam int T        = L * K,
    localparam int AW       = (T > 1) ? $clog2(T) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_i,
    input  logic signed [DW-1:0] in_q,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_i,
    output logic signed [DW-1:0] out_q,
    input  logic                 clr_status,
    output logic                 underrun,
    output logic                 sat_flag
);

    localparam int KW   = $clog2(K);
    localparam int ACCW = DW + CW + KW;
    localparam int PW   = $clog2(L);
    localparam logic [PW-1:0] P_LAST = PW'(L - 1);

    localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [PW-1:0]          phase;
    logic signed [DW-1:0]   di [K];
    logic signed [DW-1:0]   dq [K];
    logic signed [CW-1:0]   h  [T];

    logic [AW-1:0]          tap_idx;
    logic signed [ACCW-1:0] acc_i, acc_q;
    logic signed [ACCW-1:0] shf_i, shf_q;
    logic signed [DW-1:0]   sat_i, sat_q;
    logic                   clip_i, clip_q;
    logic                   slot;

    assign slot     = (phase == P_LAST);
    assign in_ready = enable && slot;

    // Branch k of the current phase uses tap k*L+phase against delay-line entry k.
    always_comb begin
        acc_i   = '0;
        acc_q   = '0;
        tap_idx = '0;
        for (int unsigned k = 0; k < K; k++) begin
            tap_idx = AW'(k * L + 32'(phase));
            acc_i   = acc_i + ACCW'(h[tap_idx]) * ACCW'(di[k]);
            acc_q   = acc_q + ACCW'(h[tap_idx]) * ACCW'(dq[k]);
        end
    end

    assign shf_i = acc_i >>> OUT_SHIFT;
    assign shf_q = acc_q >>> OUT_SHIFT;

    always_comb begin
        sat_i  = shf_i[DW-1:0];
        clip_i = 1'b0;
        if (shf_i > SMAX) begin
            sat_i  = SMAX[DW-1:0];
            clip_i = 1'b1;
        end else if (shf_i < SMIN) begin
            sat_i  = SMIN[DW-1:0];
            clip_i = 1'b1;
        end
    end

    always_comb begin
        sat_q  = shf_q[DW-1:0];
        clip_q = 1'b0;
        if (shf_q > SMAX) begin
            sat_q  = SMAX[DW-1:0];
            clip_q = 1'b1;
        end else if (shf_q < SMIN) begin
            sat_q  = SMIN[DW-1:0];
            clip_q = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase     <= P_LAST;
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            for (int unsigned k = 0; k < K; k++) begin
                di[k] <= '0;
                dq[k] <= '0;
            end
        end else if (enable) begin
            out_i     <= sat_i;
            out_q     <= sat_q;
            out_valid <= 1'b1;
            phase     <= slot ? '0 : phase + PW'(1);
            if (slot) begin
                for (int unsigned k = 1; k < K; k++) begin
                    di[k] <= di[k-1];
                    dq[k] <= dq[k-1];
                end
                // A missed symbol slot inserts a zero so the output rate never slips.
                di[0] <= in_valid ? in_i : '0;
                dq[0] <= in_valid ? in_q : '0;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned j = 0; j < T; j++) begin
                h[j] <= '0;
            end
        end else if (coef_we && (32'(coef_addr) < T)) begin
            h[coef_addr] <= coef_data;
        end
    end

    // Set events take priority over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            underrun <= (underrun & ~clr_status) | (enable & slot & ~in_valid);
            sat_flag <= (sat_flag & ~clr_status) | (enable & (clip_i | clip_q));
        end
    end

endmodule

// File: tb/tb_qpsk_tx_interp.sv
// Directed bench for qpsk_tx_interp with L=6, K=4, OUT_SHIFT=0 and h[j]=j+1.
module tb_qpsk_tx_interp;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int L  = 6;
    localparam int K  = 4;
    localparam int T  = L * K;
    localparam int AW = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_i;
    logic signed [DW-1:0] in_q;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 out_valid;
    logic signed [DW-1:0] out_i;
    logic signed [DW-1:0] out_q;
    logic                 clr_status;
    logic                 underrun;
    logic                 sat_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qpsk_tx_interp #(
        .DW(DW), .CW(CW), .L(L), .K(K), .OUT_SHIFT(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_i(out_i), .out_q(out_q),
        .clr_status(clr_status), .underrun(underrun), .sat_flag(sat_flag)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 2 * L) begin
            step();
            n++;
        end
        chk("wait_ready", in_ready, 1'b1);
    endtask

    task automatic prog_coefs();
        enable  = 1'b0;
        coef_we = 1'b1;
        for (int j = 0; j < T; j++) begin
            coef_addr = AW'(j);
            coef_data = CW'(j + 1);
            step();
        end
        coef_addr = AW'(24);
        coef_data = CW'(7777);
        step();
        coef_addr = AW'(31);
        coef_data = CW'(-1);
        step();
        coef_we = 1'b0;
    endtask

    task automatic run_impulse();
        enable   = 1'b1;
        in_valid = 1'b1;
        in_i     = 16'sd100;
        in_q     = -16'sd50;
        #1;
        chk("imp_first_ready", in_ready, 1'b1);
        step();
        chk("imp_accept_valid", out_valid, 1'b1);
        chk("imp_accept_i", out_i, 0);
        in_i = '0;
        in_q = '0;
        for (int c = 0; c < T; c++) begin
            step();
            chk("imp_i", out_i, 100 * (c + 1));
            chk("imp_q", out_q, -50 * (c + 1));
            chk("imp_ready", in_ready, (c % L) == 4);
        end
        step();
        chk("imp_tail_i", out_i, 0);
        chk("imp_tail_q", out_q, 0);
        chk("imp_underrun", underrun, 1'b0);
        chk("imp_sat", sat_flag, 1'b0);
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        in_valid   = 1'b0;
        in_i       = '0;
        in_q       = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_data  = '0;
        clr_status = 1'b0;
        repeat (2) step();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_i", out_i, 0);
        chk("rst_q", out_q, 0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_sat", sat_flag, 1'b0);
        chk("rst_ready_disabled", in_ready, 1'b0);

        reset = 1'b1;
        prog_coefs();
        chk("prog_ready", in_ready, 1'b0);
        chk("prog_valid", out_valid, 1'b0);
        run_impulse();

        // Stall and underrun
        wait_ready();
        in_i = 16'sd10;
        in_q = 16'sd20;
        step();
        in_i = '0;
        in_q = '0;
        step();
        chk("stall_p0_i", out_i, 10);
        step();
        chk("stall_p1_i", out_i, 20);
        chk("stall_p1_q", out_q, 40);
        enable = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            chk("stall_valid", out_valid, 1'b0);
            chk("stall_hold_i", out_i, 20);
            chk("stall_hold_q", out_q, 40);
            chk("stall_ready", in_ready, 1'b0);
        end
        enable = 1'b1;
        step();
        chk("resume_valid", out_valid, 1'b1);
        chk("resume_i", out_i, 30);
        chk("resume_q", out_q, 60);
        step();
        step();
        chk("slot_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        in_i     = 16'sd555;
        in_q     = 16'sd555;
        step();
        chk("ur_set", underrun, 1'b1);
        chk("ur_slot_i", out_i, 60);
        in_valid = 1'b1;
        in_i     = '0;
        in_q     = '0;
        step();
        chk("ur_zero_ins_i", out_i, 70);
        chk("ur_zero_ins_q", out_q, 140);
        chk("ur_sticky", underrun, 1'b1);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("ur_cleared", underrun, 1'b0);
        wait_ready();
        in_valid   = 1'b0;
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        in_valid   = 1'b1;
        chk("ur_set_wins", underrun, 1'b1);
        chk("ur_no_sat", sat_flag, 1'b0);

        // Coefficient rewrite between symbols
        repeat (T) step();
        wait_ready();
        in_i = 16'sd3;
        in_q = -16'sd3;
        step();
        in_i = '0;
        in_q = '0;
        step();
        chk("coef_old_i", out_i, 3);
        chk("coef_old_q", out_q, -3);
        coef_we   = 1'b1;
        coef_addr = AW'(0);
        coef_data = 16'sd50;
        step();
        coef_addr = AW'(25);
        coef_data = 16'sd1234;
        step();
        coef_we = 1'b0;
        wait_ready();
        in_i = 16'sd2;
        in_q = 16'sd4;
        step();
        in_i = '0;
        in_q = '0;
        step();
        chk("coef_new_i", out_i, 121);
        chk("coef_new_q", out_q, 179);

        // Saturation
        repeat (T) step();
        chk("pre_sat", sat_flag, 1'b0);
        coef_we   = 1'b1;
        coef_addr = AW'(0);
        coef_data = 16'sd32767;
        step();
        coef_we = 1'b0;
        wait_ready();
        in_i = 16'sd32767;
        in_q = -16'sd32768;
        step();
        in_i = '0;
        in_q = '0;
        step();
        chk("sat_pos_i", out_i, 32767);
        chk("sat_neg_q", out_q, -32768);
        chk("sat_flag", sat_flag, 1'b1);

        // Asynchronous reset mid-symbol
        step();
        #3;
        reset = 1'b0;
        #1;
        chk("arst_i", out_i, 0);
        chk("arst_q", out_q, 0);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_underrun", underrun, 1'b0);
        chk("arst_sat", sat_flag, 1'b0);
        enable = 1'b0;
        step();
        chk("arst_hold_valid", out_valid, 1'b0);
        reset = 1'b1;
        prog_coefs();
        run_impulse();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
